// File: rtl/mips_defs.sv
// Shared encodings for the multicycle MIPS subset: opcodes, functs, ALU commands,
// datapath mux selects, instruction classes and controller states.
package mips_defs;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_SLT = 3'd3
  } alu_op_e;

  localparam logic [1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd1;
  localparam logic [1:0] PC_SRC_REGA   = 2'd2;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd3;

  localparam logic [1:0] REG_DIN_ALU = 2'd0;
  localparam logic [1:0] REG_DIN_MEM = 2'd1;
  localparam logic [1:0] REG_DIN_PC4 = 2'd2;

  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_R31 = 2'd2;

  typedef enum logic [3:0] {
    IC_RALU, IC_IALU, IC_LW, IC_SW, IC_BNE, IC_J, IC_JAL, IC_JR, IC_ILLEGAL
  } instr_class_e;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

endpackage

// File: rtl/opdecode.sv
// Combinational classifier: opcode/funct to instruction class, ALU command and
// immediate-operand select.
module opdecode
  import mips_defs::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  output instr_class_e cls_o,
  output alu_op_e      alu_op_o,
  output logic         use_imm_o
);

  always_comb begin
    cls_o     = IC_ILLEGAL;
    alu_op_o  = ALU_ADD;
    use_imm_o = 1'b0;
    case (opcode_i)
      OPC_RTYPE: begin
        case (funct_i)
          FN_ADD:  cls_o = IC_RALU;
          FN_SUB:  begin cls_o = IC_RALU; alu_op_o = ALU_SUB; end
          FN_SLT:  begin cls_o = IC_RALU; alu_op_o = ALU_SLT; end
          FN_JR:   cls_o = IC_JR;
          default: cls_o = IC_ILLEGAL;
        endcase
      end
      OPC_ADDI: begin cls_o = IC_IALU; use_imm_o = 1'b1; end
      OPC_XORI: begin cls_o = IC_IALU; alu_op_o = ALU_XOR; use_imm_o = 1'b1; end
      OPC_LW:   begin cls_o = IC_LW; use_imm_o = 1'b1; end
      OPC_SW:   begin cls_o = IC_SW; use_imm_o = 1'b1; end
      OPC_BNE:  begin cls_o = IC_BNE; alu_op_o = ALU_SUB; end
      OPC_J:    cls_o = IC_J;
      OPC_JAL:  cls_o = IC_JAL;
      default:  cls_o = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with
// a memory-wait watchdog. Outputs decode state plus the IR's opcode/funct.
module multicycle_ctrl
  import mips_defs::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       aluZero,
  input  logic       memReady,
  output logic       memReq,
  output logic       irWe,
  output logic       pcWe,
  output logic       regWe,
  output logic       dmWe,
  output logic       aluBSrcCtrl,
  output logic [1:0] pcSrcCtrl,
  output logic [1:0] regDInCtrl,
  output logic [1:0] regDstCtrl,
  output logic [2:0] op,
  output logic       instrDone,
  output logic       halted,
  output logic [2:0] dbgState
);

  state_e       state_q, state_d;
  logic [3:0]   wait_q, wait_d;
  logic [3:0]   wait_inc;
  instr_class_e cls;
  alu_op_e      alu_op;
  logic         use_imm;

  opdecode u_opdecode (
    .opcode_i  (opcode),
    .funct_i   (funct),
    .cls_o     (cls),
    .alu_op_o  (alu_op),
    .use_imm_o (use_imm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign wait_inc = wait_q + 4'd1;
  assign dbgState = state_q;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    memReq      = 1'b0;
    irWe        = 1'b0;
    pcWe        = 1'b0;
    regWe       = 1'b0;
    dmWe        = 1'b0;
    aluBSrcCtrl = 1'b0;
    pcSrcCtrl   = PC_SRC_PC4;
    regDInCtrl  = REG_DIN_ALU;
    regDstCtrl  = REG_DST_RT;
    op          = ALU_ADD;
    instrDone   = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        memReq = 1'b1;
        if (memReady) begin
          irWe    = 1'b1;
          state_d = S_DECODE;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == 4'(MEM_TIMEOUT)) state_d = S_HALT;
        end
      end
      S_DECODE: begin
        case (cls)
          IC_J, IC_JAL: begin
            pcWe      = 1'b1;
            pcSrcCtrl = PC_SRC_JUMP;
            instrDone = 1'b1;
            state_d   = S_FETCH;
            if (cls == IC_JAL) begin
              regWe      = 1'b1;
              regDstCtrl = REG_DST_R31;
              regDInCtrl = REG_DIN_PC4;
            end
          end
          IC_JR: begin
            pcWe      = 1'b1;
            pcSrcCtrl = PC_SRC_REGA;
            instrDone = 1'b1;
            state_d   = S_FETCH;
          end
          IC_ILLEGAL: state_d = S_HALT;
          default:    state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        op          = alu_op;
        aluBSrcCtrl = use_imm;
        if (cls == IC_BNE) begin
          pcWe      = 1'b1;
          pcSrcCtrl = aluZero ? PC_SRC_PC4 : PC_SRC_BRANCH;
          instrDone = 1'b1;
          state_d   = S_FETCH;
        end else if (cls == IC_LW || cls == IC_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        memReq = 1'b1;
        dmWe   = (cls == IC_SW);
        if (memReady) begin
          if (cls == IC_SW) begin
            pcWe      = 1'b1;
            instrDone = 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          wait_d = wait_inc;
          if (wait_inc == 4'(MEM_TIMEOUT)) state_d = S_HALT;
        end
      end
      S_WB: begin
        regWe      = 1'b1;
        regDstCtrl = (cls == IC_RALU) ? REG_DST_RD : REG_DST_RT;
        regDInCtrl = (cls == IC_LW) ? REG_DIN_MEM : REG_DIN_ALU;
        pcWe       = 1'b1;
        instrDone  = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
    // Every state change restarts the watchdog, so FETCH and MEM always begin at zero.
    if (state_d != state_q) wait_d = '0;
    // Nothing may assert while reset is applied, whatever state the register holds.
    if (reset) begin
      memReq      = 1'b0;
      irWe        = 1'b0;
      pcWe        = 1'b0;
      regWe       = 1'b0;
      dmWe        = 1'b0;
      aluBSrcCtrl = 1'b0;
      pcSrcCtrl   = PC_SRC_PC4;
      regDInCtrl  = REG_DIN_ALU;
      regDstCtrl  = REG_DST_RT;
      op          = ALU_ADD;
      instrDone   = 1'b0;
      halted      = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, maximum cycles spent waiting on memReady in one memory state before halting.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instr[31:26] from the instruction register.
REQ-005 funct  input  6  instr[5:0] from the instruction register.
REQ-006 aluZero  input  1  ALU zero flag from the datapath.
REQ-007 memReady  input  1  memory completion for the current read/write.
REQ-008 memReq  output  1  memory access request, held until memReady.
REQ-009 irWe, pcWe, regWe, dmWe  output  1 each  write enables for instruction register, PC, regfile, data memory.
REQ-010 aluBSrcCtrl  output  1  0 = regB, 1 = imm.
REQ-011 pcSrcCtrl  output  2  0 = PC+4, 1 = jump target, 2 = regA, 3 = branch target.
REQ-012 regDInCtrl  output  2  0 = ALU, 1 = memory, 2 = PC+4.
REQ-013 regDstCtrl  output  2  0 = rt, 1 = rd, 2 = r31.
REQ-014 op  output  3  ALU command.
REQ-015 instrDone  output  1  one-cycle pulse on the last cycle of each retired instruction.
REQ-016 halted  output  1  high while in HALT.

Function
REQ-017 States: FETCH, DECODE, EXEC, MEM, WB, HALT; state held in a register.
REQ-018 FETCH: memReq=1; when memReady=1: irWe=1, next DECODE; otherwise stay.
REQ-019 DECODE: J: pcWe=1, pcSrcCtrl=1, instrDone, next FETCH; JAL: additionally regWe=1, regDstCtrl=2, regDInCtrl=2; JR (opcode 0, funct 0x08): pcWe=1, pcSrcCtrl=2, instrDone, next FETCH; recognised opcodes (0x00 ADD 0x20/SUB 0x22/SLT 0x2A, 0x08 ADDI, 0x0E XORI, 0x23 LW, 0x2B SW, 0x05 BNE) go to EXEC; any other opcode/funct goes to HALT.
REQ-020 EXEC: op per instruction (ADD/ADDI/LW/SW=ADD, SUB/BNE=SUB, SLT=SLT, XORI=XOR); aluBSrcCtrl=1 for ADDI/XORI/LW/SW; BNE: pcWe=1, pcSrcCtrl=3 if aluZero=0, else pcSrcCtrl=0; BNE asserts instrDone and goes to FETCH; LW/SW go to MEM; others go to WB.
REQ-021 Non-branch instructions: pcWe=1, pcSrcCtrl=0 on the final cycle.
REQ-022 MEM: memReq=1; SW: dmWe=1 throughout; on memReady SW retires (instrDone, pcWe) and goes to FETCH; LW goes to WB.
REQ-023 WB: regWe=1; R-type regDstCtrl=1, regDInCtrl=0; I-type ALU regDstCtrl=0, regDInCtrl=0; LW regDstCtrl=0, regDInCtrl=1; instrDone, next FETCH.
REQ-024 Wait counter: 4 bits; cleared on entry to FETCH/MEM; increments each cycle without memReady; on reaching MEM_TIMEOUT go to HALT.
REQ-025 memReady is ignored outside FETCH/MEM.
REQ-026 All write enables are 0 in any cycle not listed above; regWe never asserts when the destination register is 0 (this gating is the datapath's responsibility, not the controller's).
REQ-027 HALT: all enables 0, halted=1, exit only on reset.
REQ-028 Latency: J/JR/JAL 2 cycles, BNE 3, ALU ops 4, SW 4, LW 5, each plus memory wait cycles.

Reset
REQ-029 reset=1 forces state FETCH, wait counter 0, all enables 0, instrDone=0, halted=0 at the next edge; this applies in any state, including mid-MEM with dmWe asserted.
REQ-030 Outputs are a combinational decode of state and the latched opcode/funct; no output asserts in the reset cycle.

Structure
REQ-031 Opcode, funct, ALU op (ADD=0, SUB=1, XOR=2, SLT=3), and mux select encodings belong in shared package mips_defs, which the decoder and ALU also use.
REQ-032 Sub-module: opdecode (combinational opcode/funct to instruction class), instantiated once.

Verification
REQ-033 ADD with memReady tied to 1 -> irWe in cycle 1, regWe + regDstCtrl=1 in cycle 4, exactly one instrDone pulse.
REQ-034 LW with memReady delayed 3 cycles in MEM -> dmWe never asserts, regDInCtrl=1 in WB, total 8 cycles.
REQ-035 BNE, once with aluZero=0 and once with aluZero=1 -> pcSrcCtrl=3 and pcSrcCtrl=0 respectively, pcWe in cycle 3.
REQ-036 JAL -> regDstCtrl=2, regDInCtrl=2, pcSrcCtrl=1 in cycle 2; opcode 0x3F -> halted=1 from cycle 3 until reset.
REQ-037 memReady held at 0 in FETCH -> HALT after 15 wait cycles; reset asserted mid-MEM during SW -> dmWe=0 and state FETCH at the next edge.
